// File: rtl/aes_kx_pkg.sv
// Shared AES key-expansion definitions: key-size modes, the GF(2^8)
// reduction constant, the first round constant and per-mode round counts.
package aes_kx_pkg;

  // Key size carried on the two-bit mode input.
  typedef enum logic [1:0] {
    AES_128  = 2'd0,
    AES_192  = 2'd1,
    AES_256  = 2'd2,
    AES_RSVD = 2'd3
  } aes_mode_e;

  // Sequencer states of the round-constant generator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } rcon_state_e;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] XTIME_POLY = 8'h1B;

  // First round constant of every sequence.
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Number of round constants consumed by each key size.
  localparam logic [3:0] ROUNDS_AES128 = 4'd10;
  localparam logic [3:0] ROUNDS_AES192 = 4'd8;
  localparam logic [3:0] ROUNDS_AES256 = 4'd7;

  // Sequence length for a latched mode; the reserved code behaves as AES-128.
  function automatic logic [3:0] rcon_len(input aes_mode_e m);
    logic [3:0] len;
    case (m)
      AES_128: len = ROUNDS_AES128;
      AES_192: len = ROUNDS_AES192;
      AES_256: len = ROUNDS_AES256;
      default: len = ROUNDS_AES128;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/gf_xtime.sv
// Multiplication by x in GF(2^8) with the AES polynomial. Purely
// combinational so it can be shared with MixColumns datapaths.
module gf_xtime
  import aes_kx_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Shift left and fold the carried-out bit back in with the reduction byte.
  always_comb begin
    dout = {din[6:0], 1'b0};
    if (din[7]) begin
      dout = {din[6:0], 1'b0} ^ XTIME_POLY;
    end else begin
      dout = {din[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/rcon_gen.sv
// AES key-schedule round-constant generator. After a start it presents
// 01,02,04,... one word per valid/ready handshake, flags the final word,
// and pulses done once the sequence has been fully consumed. The next
// constant is computed with gf_xtime from the current byte, so no table
// is needed and back-to-back handshakes run without bubbles.
module rcon_gen
  import aes_kx_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              rcon_ready,
  output logic              rcon_valid,
  output logic [WORD_W-1:0] rcon_word,
  output logic [CNT_W-1:0]  round_idx,
  output logic              rcon_last,
  output logic              busy,
  output logic              done
);

  rcon_state_e      state_r;
  aes_mode_e        mode_r;
  logic [7:0]       byte_r;
  logic [CNT_W-1:0] idx_r;
  logic             valid_r;
  logic             last_r;
  logic             busy_r;
  logic             done_r;

  logic [7:0]       byte_next_s;
  logic [CNT_W-1:0] len_s;
  logic [CNT_W-1:0] len_start_s;
  logic [CNT_W-1:0] idx_next_s;
  logic             handshake_s;

  gf_xtime u_xtime (
    .din  (byte_r),
    .dout (byte_next_s)
  );

  // Sequence length of the latched mode, and of the mode offered with start.
  always_comb begin
    len_s       = CNT_W'(rcon_len(mode_r));
    len_start_s = CNT_W'(rcon_len(aes_mode_e'(mode)));
    idx_next_s  = idx_r + {{(CNT_W-1){1'b0}}, 1'b1};
    handshake_s = valid_r & rcon_ready;
  end

  // Sequencer with all outputs registered; abort overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      mode_r  <= AES_128;
      byte_r  <= 8'h00;
      idx_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (abort) begin
      state_r <= ST_IDLE;
      byte_r  <= 8'h00;
      idx_r   <= {CNT_W{1'b0}};
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ST_RUN;
            mode_r  <= aes_mode_e'(mode);
            byte_r  <= RCON_INIT;
            idx_r   <= {{(CNT_W-1){1'b0}}, 1'b1};
            valid_r <= 1'b1;
            last_r  <= (len_start_s == {{(CNT_W-1){1'b0}}, 1'b1});
            busy_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            byte_r  <= 8'h00;
            idx_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_RUN: begin
          done_r <= 1'b0;
          busy_r <= 1'b1;
          if (handshake_s && (idx_r == len_s)) begin
            // Final word taken: drop valid and spend one cycle in FIN.
            state_r <= ST_FIN;
            byte_r  <= 8'h00;
            idx_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
          end else if (handshake_s) begin
            state_r <= ST_RUN;
            byte_r  <= byte_next_s;
            idx_r   <= idx_next_s;
            valid_r <= 1'b1;
            last_r  <= (idx_next_s == len_s);
          end else begin
            // Stall: hold the presented word until the consumer takes it.
            state_r <= ST_RUN;
            byte_r  <= byte_r;
            idx_r   <= idx_r;
            valid_r <= valid_r;
            last_r  <= last_r;
          end
        end
        ST_FIN: begin
          state_r <= ST_IDLE;
          byte_r  <= 8'h00;
          idx_r   <= {CNT_W{1'b0}};
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          byte_r  <= 8'h00;
          idx_r   <= {CNT_W{1'b0}};
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Present the byte zero-extended to the output word width.
  always_comb begin
    rcon_valid = valid_r;
    rcon_word  = WORD_W'(byte_r);
    round_idx  = idx_r;
    rcon_last  = last_r;
    busy       = busy_r;
    done       = done_r;
  end

endmodule

// File: tb/tb_rcon_gen.sv
// Randomised self-checking bench for rcon_gen. A cycle-level reference model
// tracks which constant (by position in the AES Rcon list) should be shown.
module tb_rcon_gen;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   mode;
  logic         abort;
  logic         rcon_ready;

  logic         rcon_valid;
  logic [31:0]  rcon_word;
  logic [3:0]   round_idx;
  logic         rcon_last;
  logic         busy;
  logic         done;

  logic         w_valid;
  logic [127:0] w_word;
  logic [3:0]   w_idx;
  logic         w_last;
  logic         w_busy;
  logic         w_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: the published AES round constants in order.
  logic [7:0] rcon_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

  // Model state
  bit m_valid;
  int m_k;
  int m_len;
  bit m_fin;
  bit m_done;

  logic [7:0] got[$];
  int         done_seen;

  always #5 clk = ~clk;

  rcon_gen #(.WORD_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .rcon_ready(rcon_ready), .rcon_valid(rcon_valid), .rcon_word(rcon_word),
    .round_idx(round_idx), .rcon_last(rcon_last), .busy(busy), .done(done)
  );

  rcon_gen #(.WORD_W(128), .CNT_W(4)) dut_wide (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
    .rcon_ready(rcon_ready), .rcon_valid(w_valid), .rcon_word(w_word),
    .round_idx(w_idx), .rcon_last(w_last), .busy(w_busy), .done(w_done)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input logic [1:0] md);
    case (md)
      2'd1:    return 8;
      2'd2:    return 7;
      default: return 10;
    endcase
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_k = 0; m_fin = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_update(input logic s, input logic [1:0] md, input logic ab, input logic rdy);
    if (ab) begin
      model_clear();
    end else if (m_valid) begin
      m_done = 1'b0;
      if (rdy) begin
        if (m_k == m_len) begin
          m_valid = 1'b0; m_k = 0; m_fin = 1'b1;
        end else begin
          m_k++;
        end
      end
    end else if (m_fin) begin
      m_fin = 1'b0; m_done = 1'b1;
    end else begin
      m_done = 1'b0;
      if (s) begin
        m_valid = 1'b1; m_k = 1; m_len = len_of(md);
        got.delete();
      end
    end
  endtask

  task automatic compare_outputs();
    logic [7:0] ew;
    ew = m_valid ? rcon_tbl[m_k-1] : 8'h00;
    check_val("valid", rcon_valid, m_valid);
    check_val("word", rcon_word, ew);
    check_val("idx", round_idx, m_valid ? m_k : 0);
    check_val("last", rcon_last, m_valid && (m_k == m_len));
    check_val("busy", busy, m_valid || m_fin);
    check_val("done", done, m_done);
    check_val("wide_valid", w_valid, m_valid);
    check_val("wide_upper", w_word[127:8], 0);
    check_val("wide_low", w_word[7:0], ew);
  endtask

  // One clock: drive, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic s, input logic [1:0] md, input logic ab, input logic rdy);
    start = s; mode = md; abort = ab; rcon_ready = rdy;
    @(negedge clk);
    compare_outputs();
    if (rcon_valid && rdy) got.push_back(rcon_word[7:0]);
    if (done) done_seen++;
    @(posedge clk);
    model_update(s, md, ab, rdy);
    #1;
  endtask

  // Run a full sequence; pat 0=ready high, 1=toggling, 2=random.
  task automatic run_seq(input logic [1:0] md, input int pat, input bit noise,
                         input bit do_start, input bit chain, input logic [1:0] chain_md);
    int len;
    logic rdy;
    len = len_of(md);
    done_seen = 0;
    if (do_start) step(1'b1, md, 1'b0, 1'b1);
    for (int c = 0; c < 80; c++) begin
      if (pat == 0) rdy = 1'b1;
      else if (pat == 1) rdy = c[0];
      else rdy = 1'($urandom_range(0, 1));
      step(noise && m_valid && ($urandom_range(0, 2) == 0),
           noise ? 2'($urandom) : md, 1'b0, rdy);
      if (m_done) break;
    end
    check_val("seq_len", got.size(), len);
    for (int i = 0; i < len && i < got.size(); i++)
      check_val("seq_word", got[i], rcon_tbl[i]);
    step(chain, chain_md, 1'b0, 1'b1);
    check_val("done_pulses", done_seen, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; abort = 1'b0; rcon_ready = 1'b0;
    model_clear(); m_len = 10;
    #23;
    compare_outputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode 0, always ready; then chained back-to-back mode 0 restart.
    run_seq(2'd0, 0, 1'b0, 1'b1, 1'b1, 2'd0);
    check_val("b2b_busy", busy, 1'b1);
    check_val("b2b_word", rcon_word, 32'h01);
    run_seq(2'd0, 0, 1'b0, 1'b0, 1'b0, 2'd0);

    // Mode 2 with toggling ready.
    run_seq(2'd2, 1, 1'b0, 1'b1, 1'b0, 2'd0);

    // Mode 1 aborted at idx 5, abort colliding with start and handshake.
    done_seen = 0;
    step(1'b1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (m_valid && m_k == 5) break;
      step(1'b0, 2'd1, 1'b0, 1'b1);
    end
    check_val("abort_at_idx", round_idx, 4'd5);
    step(1'b1, 2'd0, 1'b1, 1'b1);
    check_val("abort_valid", rcon_valid, 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check_val("abort_no_done", done_seen, 0);
    step(1'b1, 2'd0, 1'b0, 1'b0);
    check_val("restart_word", rcon_word, 32'h01);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 1'b0);

    // Asynchronous reset mid-sequence at idx 9.
    step(1'b1, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (m_valid && m_k == 9) break;
      step(1'b0, 2'd0, 1'b0, 1'b1);
    end
    check_val("pre_reset_word", rcon_word, 32'h1B);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    compare_outputs();
    check_val("rst_idx", round_idx, 4'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, 2'd0, 1'b0, 1'b1);
    run_seq(2'd0, 2, 1'b0, 1'b1, 1'b0, 2'd0);

    // Reserved mode behaves as AES-128, with start/mode noise while running.
    run_seq(2'd3, 2, 1'b1, 1'b1, 1'b0, 2'd0);
    run_seq(2'd1, 2, 1'b1, 1'b1, 1'b0, 2'd0);

    // Free-running random traffic against the model.
    for (int c = 0; c < 600; c++)
      step(1'($urandom_range(0, 3) == 0), 2'($urandom), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
